// File: rtl/r5p_tcb_arb.sv
// r5p_tcb_arb: merges load/store (m0) and fetch (m1) TCB managers onto one subordinate,
// holding the grant across stalls and routing each response back through a DLY-deep ID pipeline.
module r5p_tcb_arb #(
    parameter int   ABW = 32,
    parameter int   DBW = 32,
    parameter int   BEW = DBW/8,
    parameter int   DLY = 1,
    parameter logic RRB = 1'b0
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_vld,
    input  logic [BEW+ABW+DBW:0]     m0_req,
    output logic                     m0_rdy,
    output logic [DBW:0]             m0_rsp,
    input  logic                     m1_vld,
    input  logic [BEW+ABW+DBW:0]     m1_req,
    output logic                     m1_rdy,
    output logic [DBW:0]             m1_rsp,
    output logic                     s_vld,
    output logic [BEW+ABW+DBW:0]     s_req,
    input  logic                     s_rdy,
    input  logic [DBW:0]             s_rsp
);
    logic lck_q, lck_d, own_q, own_d, lst_q, lst_d, gnt, trn;
    always_comb begin
        gnt   = lck_q ? own_q : (m0_vld & m1_vld) ? (RRB & ~lst_q) : (m1_vld & ~m0_vld);
        s_vld = gnt ? m1_vld : m0_vld;
        s_req = gnt ? m1_req : m0_req;
        m0_rdy = s_rdy & ~gnt;
        m1_rdy = s_rdy & gnt;
        trn   = s_vld & s_rdy;
        // a stalled request keeps its owner; a dropped or accepted one releases the lock
        lck_d = s_vld & ~s_rdy;
        own_d = lck_d ? gnt : own_q;
        lst_d = trn ? gnt : lst_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lck_q <= 1'b0;
            own_q <= 1'b0;
            lst_q <= 1'b1;
        end else begin
            lck_q <= lck_d;
            own_q <= own_d;
            lst_q <= lst_d;
        end
    end
    if (DLY > 0) begin : g_pipe
        logic [DLY-1:0] v_q, id_q;
        logic [DLY:0]   v_d, id_d;
        always_comb begin
            v_d  = {v_q, trn};
            id_d = {id_q, trn & gnt};
            m0_rsp = (v_q[DLY-1] & ~id_q[DLY-1]) ? s_rsp : '0;
            m1_rsp = (v_q[DLY-1] &  id_q[DLY-1]) ? s_rsp : '0;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q  <= '0;
                id_q <= '0;
            end else begin
                v_q  <= v_d[DLY-1:0];
                id_q <= id_d[DLY-1:0];
            end
        end
    end else begin : g_comb
        always_comb begin
            m0_rsp = (~rst & trn & ~gnt) ? s_rsp : '0;
            m1_rsp = (~rst & trn &  gnt) ? s_rsp : '0;
        end
    end
    // the locked owner must keep its request valid until accepted
    a_hold: assert property (@(posedge clk) disable iff (rst) lck_q |-> s_vld);
endmodule

// File: tb/tb_r5p_tcb_arb.sv
// tb_r5p_tcb_arb: random protocol-abiding traffic into four arbiter configurations,
// each checked every cycle against a queue-based model of grant, lock and response delay.
module tb_r5p_tcb_arb;
    localparam int RQW = 69;
    localparam int RSW = 33;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_err = 0;
    int   pv = 0, pr = 100;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [95:0] rnd();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int   DL = (g == 2) ? 2 : (g == 3) ? 0 : 1;
        localparam logic RR = (g == 1 || g == 2);
        logic           m0_vld = 1'b0, m1_vld = 1'b0, s_rdy = 1'b0;
        logic [RQW-1:0] m0_req = '0, m1_req = '0;
        logic [RSW-1:0] s_rsp = '0;
        logic           m0_rdy, m1_rdy, s_vld;
        logic [RSW-1:0] m0_rsp, m1_rsp;
        logic [RQW-1:0] s_req;
        logic           lk = 1'b0, ow = 1'b0, lst = 1'b1, acc0 = 1'b0, acc1 = 1'b0;
        int             q[$];

        r5p_tcb_arb #(.DLY(DL), .RRB(RR)) dut (
            .clk(clk), .rst(rst),
            .m0_vld(m0_vld), .m0_req(m0_req), .m0_rdy(m0_rdy), .m0_rsp(m0_rsp),
            .m1_vld(m1_vld), .m1_req(m1_req), .m1_rdy(m1_rdy), .m1_rsp(m1_rsp),
            .s_vld(s_vld), .s_req(s_req), .s_rdy(s_rdy), .s_rsp(s_rsp)
        );

        // managers hold a request until the model says it was accepted
        always @(posedge clk) begin
            logic [95:0] t;
            #1;
            if (rst) begin
                m0_vld = 1'b0;
                m1_vld = 1'b0;
            end else begin
                if (!m0_vld || acc0) begin
                    t = rnd();
                    m0_vld = $urandom_range(99) < pv;
                    m0_req = t[RQW-1:0];
                end
                if (!m1_vld || acc1) begin
                    t = rnd();
                    m1_vld = $urandom_range(99) < pv;
                    m1_req = t[RQW-1:0];
                end
            end
            s_rdy = $urandom_range(99) < pr;
            t = rnd();
            s_rsp = t[RSW-1:0];
        end

        always @(negedge clk) begin
            logic g_e, v_e, tx;
            int   tail;
            if (rst) begin
                lk = 1'b0; ow = 1'b0; lst = 1'b1;
                q.delete();
                repeat (DL) q.push_back(-1);
            end
            if (lk) g_e = ow;
            else if (m0_vld && m1_vld) g_e = RR ? !lst : 1'b0;
            else g_e = m1_vld && !m0_vld;
            v_e = g_e ? m1_vld : m0_vld;
            tx  = !rst && v_e && s_rdy;
            chk($sformatf("c%0d s_vld", g), s_vld, v_e);
            chk($sformatf("c%0d s_req", g), s_req, g_e ? m1_req : m0_req);
            chk($sformatf("c%0d m0_rdy", g), m0_rdy, s_rdy && !g_e);
            chk($sformatf("c%0d m1_rdy", g), m1_rdy, s_rdy && g_e);
            tail = (DL > 0) ? q[0] : (tx ? int'(g_e) : -1);
            chk($sformatf("c%0d m0_rsp", g), m0_rsp, (tail == 0) ? s_rsp : '0);
            chk($sformatf("c%0d m1_rsp", g), m1_rsp, (tail == 1) ? s_rsp : '0);
            acc0 = tx && !g_e;
            acc1 = tx && g_e;
            if (!rst) begin
                if (tx) lst = g_e;
                lk = v_e && !s_rdy;
                if (lk) ow = g_e;
                if (DL > 0) begin
                    q.push_back(tx ? int'(g_e) : -1);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic phase(input int v, input int r, input int n);
        pv = v;
        pr = r;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        phase(100, 100, 20);
        phase(90, 100, 400);
        phase(90, 30, 400);
        phase(40, 70, 400);
        phase(20, 100, 300);
        // reset with responses still in flight
        phase(90, 100, 5);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        phase(100, 100, 20);
        phase(70, 50, 400);
        phase(0, 100, 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/r5p_tcb_arb.md
Name: r5p_tcb_arb

Overview:
Two-manager to one-subordinate TCB bus arbiter. It merges the core's load/store bus (m0) and instruction-fetch bus (m1) onto a single memory port, so the Degu core can run on single-port memory. It holds the grant stable while a request is stalled. It routes each response back to its originator through a DLY-deep grant-ID pipeline.

Parameters:
ABW, 32, address width
DBW, 32, data width
BEW, DBW/8, byte enable width
DLY, 1, subordinate response latency in cycles (0 = combinational response)
RRB, 1'b0, arbitration policy: 0 = fixed priority (m0 wins), 1 = round-robin

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
m0_vld  input  1  load/store request valid
m0_req  input  1+BEW+ABW+DBW  packed {wen, ben, adr, wdt}
m0_rdy  output  1  load/store request accepted
m0_rsp  output  1+DBW  packed {err, rdt}
m1_vld  input  1  fetch request valid
m1_req  input  1+BEW+ABW+DBW  packed {wen, ben, adr, wdt}
m1_rdy  output  1  fetch request accepted
m1_rsp  output  1+DBW  packed {err, rdt}
s_vld  output  1  subordinate request valid
s_req  output  1+BEW+ABW+DBW  muxed request
s_rdy  input  1  subordinate ready
s_rsp  input  1+DBW  subordinate response {err, rdt}

Behaviour:
- Transfer on any port is vld & rdy in the same cycle. The response appears on the matching rsp exactly DLY cycles after the transfer.
- State registers:
  - lck: grant locked.
  - own: locked owner, 0 or 1.
  - lst: last served manager.
  - pipeline of DLY entries of {v, id}.
- Reset values: lck=0, own=0, lst=1, all pipeline v=0.
- Reset outputs: m0_rsp=0, m1_rsp=0. s_vld/s_req/mX_rdy are combinational from the inputs; with m0_vld=m1_vld=0 they give s_vld=0 and rdy=0.
- Grant selection (gnt):
  - If lck: gnt=own.
  - Else if only one vld is high: gnt=that manager.
  - Else if both are high: RRB=0 gives gnt=0; RRB=1 gives gnt=~lst.
  - Else (neither valid): gnt=0, but s_vld=0.
- Request path:
  - s_vld = gnt ? m1_vld : m0_vld.
  - s_req = request of gnt.
  - mX_rdy = s_rdy & (gnt==X).
  - The non-granted manager always sees rdy=0.
- Lock: on a cycle with s_vld & ~s_rdy, set lck=1 and own=gnt. A higher-priority request arriving while locked must not change s_req; this preserves the TCB rule that a request stays stable until accepted.
- Unlock:
  - lck clears on the cycle s_vld & s_rdy.
  - The next cycle arbitrates fresh, so back-to-back transfers from different managers are allowed with no bubble.
  - If the owner drops vld while locked (protocol violation), lck clears and a simulation assertion fires.
- lst updates to gnt on every transfer. It is used only when RRB=1.
- Response routing (DLY>0):
  - On a transfer, push {1,gnt} into pipeline stage 0; otherwise push {0,x}.
  - Advance one stage per cycle, independent of s_rdy.
  - At the tail: if v & id==X, mX_rsp=s_rsp, else mX_rsp=0.
- Response routing (DLY=0): mX_rsp = s_rsp when s_vld & s_rdy & gnt==X, else 0.
- Pipelining: one new transfer per cycle is allowed. The pipeline always holds up to DLY outstanding responses; no back-pressure on responses.
- Starvation: under RRB=0, a continuously valid m0 starves m1. This is accepted for fixed priority. RRB=1 guarantees at most 1 intervening m0 transfer.
- Reset mid-operation: lock and pipeline are cleared and outstanding responses are discarded (both rsp forced to 0).
- Width: all muxing is bitwise on packed vectors; no arithmetic. Request packing order is fixed as {wen, ben, adr, wdt} MSB to LSB.

Test Plan:
- Only m1_vld=1, adr=0x100, s_rdy=1, DLY=1 -> s_req.adr=0x100 and m1_rdy=1 the same cycle; next cycle m1_rsp.rdt=s_rsp.rdt=0xDEADBEEF, m0_rsp=0.
- Both valid, RRB=0, s_rdy=1 for 3 cycles -> m0_rdy=1 and m1_rdy=0 every cycle; s_req carries m0 address each cycle.
- Both valid, RRB=1, s_rdy=1 for 4 cycles, after reset -> grants m0, m1, m0, m1; responses alternate m0_rsp/m1_rsp one cycle later.
- m1 alone valid, s_rdy=0 for 3 cycles, m0_vld rises on cycle 2 -> s_req stays m1's for all 3 stall cycles; when s_rdy=1, m1 transfers and m0 is granted the following cycle.
- Transfer issued, then rst asserted before DLY=2 elapses -> both rsp=0, no response delivered; after release the first transfer routes correctly.
- DLY=0, m0 write wen=1, ben=0xF, s_rsp.err=1 -> m0_rsp.err=1 in the same cycle, m1_rsp.err=0.
